// File: rtl/add.sv
// Registered modular adder/subtractor: sum = (a op b) mod P for 256-bit signed operands.
// Define ADD_INPUT_REG_EN to register the operands first (latency 2 instead of 1).
module add #(
  parameter logic [255:0] P = 256'd17
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [255:0] a,
  input  logic [255:0] b,
  input  logic         op,
  output logic [255:0] sum
);

  localparam int W  = 256;
  localparam int TW = W + 2;
  localparam logic [TW-1:0] P_EXT = {2'b00, P};

  logic [W-1:0] s_a;
  logic [W-1:0] s_b;
  logic         s_op;

`ifdef ADD_INPUT_REG_EN
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         op_q;

  // NOTE: every pipeline register uses the asynchronous reset, so a reset
  // mid-stream leaves nothing stale behind once it is released.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 1'b0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

  assign s_a  = a_q;
  assign s_b  = b_q;
  assign s_op = op_q;
`else
  assign s_a  = a;
  assign s_b  = b;
  assign s_op = op;
`endif

  // Two extra sign bits make the sum or difference of two 256-bit values exact.
  logic signed [TW-1:0] ext_a;
  logic signed [TW-1:0] ext_b;
  logic signed [TW-1:0] t_d;

  assign ext_a = $signed({{2{s_a[W-1]}}, s_a});
  assign ext_b = $signed({{2{s_b[W-1]}}, s_b});
  assign t_d   = s_op ? (ext_a - ext_b) : (ext_a + ext_b);

  // Floored modulo: reduce |t|, then reflect a nonzero remainder of a negative t.
  logic          t_neg;
  logic [TW-1:0] mag;
  logic [W-1:0]  rem;
  logic [W-1:0]  sum_d;

  assign t_neg = t_d[TW-1];

  always_comb begin
    // NOTE: always_comb uses blocking assignments, and every output is
    // assigned on every path so no latch is inferred.
    mag   = t_neg ? $unsigned(-t_d) : $unsigned(t_d);
    rem   = W'(mag % P_EXT);
    sum_d = rem;
    if (t_neg && (rem != '0)) begin
      sum_d = P - rem;
    end
  end

  logic [W-1:0] sum_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_add.sv
// Self-checking bench for add: random and directed vectors against a residue-based
// reference model, checked by a scoreboard monitor decoupled from the stimulus.
module tb_add;

  localparam logic [255:0] P = 256'd17;
`ifdef ADD_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         Clk;
  logic         Reset;
  logic [255:0] a;
  logic [255:0] b;
  logic         op;
  logic [255:0] sum;

  add #(.P(P)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .a    (a),
    .b    (b),
    .op   (op),
    .sum  (sum)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int unsigned edges = 0;
  always @(posedge Clk) edges <= edges + 1;

  typedef struct {
    int unsigned  due;
    logic [255:0] exp;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: reduce each operand to [0,P) separately, then combine the residues.
  function automatic logic [255:0] fmod(input logic [255:0] x);
    logic signed [257:0] xs;
    logic signed [257:0] pm;
    logic signed [257:0] r;
    xs = $signed({{2{x[255]}}, x});
    pm = $signed({2'b00, P});
    r  = xs % pm;
    if (r < 0) r = r + pm;
    return r[255:0];
  endfunction

  function automatic logic [255:0] ref_model(input logic [255:0] av, input logic [255:0] bv,
                                             input logic opv);
    logic [256:0] ra;
    logic [256:0] rb;
    logic [256:0] pp;
    logic [256:0] s;
    ra = {1'b0, fmod(av)};
    rb = {1'b0, fmod(bv)};
    pp = {1'b0, P};
    if (!opv) s = ra + rb;
    else      s = ra + pp - rb;
    if (s >= pp) s = s - pp;
    return s[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 5))
      0:       v = {1'b0, {255{1'b1}}};
      1:       v = {1'b1, 255'd0};
      2:       v = {256{1'b1}};
      3:       v = 256'($urandom_range(0, 40));
      default: ;
    endcase
    return v;
  endfunction

  // Called at a negedge; applies one vector and returns at the next negedge.
  task automatic drive(input logic [255:0] av, input logic [255:0] bv, input logic opv,
                       input string tag);
    a  = av;
    b  = bv;
    op = opv;
    sb.push_back('{due: edges + LAT, exp: ref_model(av, bv, opv), tag: tag});
    @(negedge Clk);
  endtask

  // Called at a negedge; until the first real result arrives the output must stay 0.
  task automatic release_reset();
    Reset = 1'b1;
    for (int k = 1; k < LAT; k++) sb.push_back('{due: edges + k, exp: '0, tag: "post_reset_zero"});
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      while (sb.size() > 0 && sb[0].due <= edges) begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, sum, e.exp);
      end
    end
  end

  logic [255:0] max_pos;
  logic [255:0] min_neg;

  initial begin
    max_pos = {1'b0, {255{1'b1}}};
    min_neg = {1'b1, 255'd0};
    Reset = 1'b0;
    a     = '0;
    b     = '0;
    op    = 1'b0;
    repeat (2) @(negedge Clk);
    a = rand256();
    b = rand256();
    #1 check("reset_hold", sum, '0);
    @(negedge Clk);

    release_reset();
    drive(256'd6, -256'sd16, 1'b1, "sub_6_m16");
    drive(256'd6, -256'sd16, 1'b0, "add_6_m16");
    drive(256'd17, 256'd0, 1'b0, "multiple_of_p");
    drive(256'd0, 256'd0, 1'b1, "zero_sub");
    drive({256{1'b1}}, {256{1'b1}}, 1'b0, "m1_plus_m1");
    drive(max_pos, 256'd0, 1'b0, "max_pos");
    drive(min_neg, 256'd0, 1'b0, "min_neg");
    drive(min_neg, max_pos, 1'b1, "min_minus_max");
    drive(max_pos, min_neg, 1'b1, "max_minus_min");
    drive(max_pos, max_pos, 1'b0, "max_plus_max");
    drive(min_neg, min_neg, 1'b0, "min_plus_min");
    for (int i = 0; i < 4; i++) drive(256'd6, -256'sd16, 1'(i % 2), "alternate");
    for (int i = 0; i < 300; i++) drive(rand256(), rand256(), 1'($urandom_range(0, 1)), "random");

    // Reset while results are in flight: output clears at once, nothing stale afterwards.
    for (int i = 0; i < 3; i++) drive(rand256(), rand256(), 1'($urandom_range(0, 1)), "pre_reset");
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1 check("async_reset_clear", sum, '0);
    sb.delete();
    a = 256'd5;
    b = 256'd3;
    @(negedge Clk);
    check("reset_held_zero", sum, '0);
    release_reset();
    drive(256'd6, -256'sd16, 1'b0, "after_reset");
    for (int i = 0; i < 50; i++) drive(rand256(), rand256(), 1'($urandom_range(0, 1)), "random2");

    repeat (LAT + 2) @(negedge Clk);
    check("scoreboard_drained", 256'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
